// File: rtl/conv3_seq_pkg.sv
// -----------------------------------------------------------------------------
// conv3_seq_pkg
// Shared definitions for the sequential 3x3 convolution engine:
//   - FSM state encoding and a packed debug/status view of the engine
//   - derived sizes (lanes, groups, RAM depth, partial/accumulator widths)
//     as functions of the top-level parameters
//   - CTRL/STATUS register addresses and STATUS bit positions
// -----------------------------------------------------------------------------
package conv3_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } conv3_state_e;

    // Observable engine state: FSM state plus the sticky flags.
    typedef struct packed {
        conv3_state_e state;
        logic         err;
        logic         done;
    } conv3_dbg_t;

    // A 3x3 kernel occupies 9 words per channel group.
    localparam int TAPS = 9;

    localparam int STATUS_DONE_BIT = 0;
    localparam int STATUS_BUSY_BIT = 1;
    localparam int STATUS_ERR_BIT  = 2;

    function automatic int f_lanes(input int data_w, input int prec_w);
        return data_w / prec_w;
    endfunction

    function automatic int f_groups(input int channels, input int lanes);
        return channels / lanes;
    endfunction

    function automatic int f_ram_depth(input int out_points, input int groups);
        return (out_points + 1) * groups * TAPS;
    endfunction

    // 72 products of two prec_w-bit values: 2*prec_w bits each, 7 bits of growth.
    function automatic int f_part_w(input int prec_w);
        return 2 * prec_w + 7;
    endfunction

    function automatic int f_acc_w(input int prec_w, input int groups);
        return f_part_w(prec_w) + $clog2(groups);
    endfunction

    function automatic int f_ctrl_addr(input int addr_w);
        return (1 << addr_w) - 2;
    endfunction

    function automatic int f_status_addr(input int addr_w);
        return (1 << addr_w) - 1;
    endfunction

endpackage

// File: rtl/conv3_seq_engine_group_mac.sv
// -----------------------------------------------------------------------------
// conv3_group_mac
// Combinational multiply-accumulate for one output point and one channel
// group: 9 data words against 9 weight words, LANES elements per word,
// element-wise products summed into a single partial.
//
// Optional build macro: CONV3_SIGNED_EN (elements are two's complement).
//
// Ports:
//   data_i     9 packed data words, word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   weight_i   9 packed weight words, same layout
//   partial_o  sum of all 9*LANES products, 2*PRECISION_WIDTH+7 bits
// -----------------------------------------------------------------------------
module conv3_group_mac
    import conv3_seq_pkg::*;
#(
    parameter int PRECISION_WIDTH = 4,
    parameter int DATA_WIDTH      = 32
) (
    input  logic [TAPS*DATA_WIDTH-1:0]      data_i,
    input  logic [TAPS*DATA_WIDTH-1:0]      weight_i,
    output logic [f_part_w(PRECISION_WIDTH)-1:0] partial_o
);

    localparam int LANES  = f_lanes(DATA_WIDTH, PRECISION_WIDTH);
    localparam int PART_W = f_part_w(PRECISION_WIDTH);

    // Widen an element to the partial width; the sum of all products fits
    // exactly, so modular arithmetic at PART_W is exact in both modes.
    function automatic logic [PART_W-1:0] ext_elem(input logic [PRECISION_WIDTH-1:0] v);
`ifdef CONV3_SIGNED_EN
        return PART_W'(signed'(v));
`else
        return PART_W'(v);
`endif
    endfunction

    logic [PART_W-1:0]          sum;
    logic [PRECISION_WIDTH-1:0] a;
    logic [PRECISION_WIDTH-1:0] b;

    // Elements stream MSB-nibble first within each word; data and weights
    // share the layout, so pairing by position pairs channel/row/column.
    always_comb begin
        sum = '0;
        a   = '0;
        b   = '0;
        for (int w = 0; w < TAPS; w++) begin
            for (int n = 0; n < LANES; n++) begin
                a   = data_i[w*DATA_WIDTH + DATA_WIDTH - 1 - n*PRECISION_WIDTH -: PRECISION_WIDTH];
                b   = weight_i[w*DATA_WIDTH + DATA_WIDTH - 1 - n*PRECISION_WIDTH -: PRECISION_WIDTH];
                sum = sum + ext_elem(a) * ext_elem(b);
            end
        end
        partial_o = sum;
    end

endmodule

// File: rtl/conv3_seq_engine.sv
// -----------------------------------------------------------------------------
// conv3_seq_engine
// Memory-mapped 3x3 convolution engine. Operands live in an internal
// word-addressed RAM; a CTRL write starts a run that processes one 8-channel
// group per cycle for every output point, accumulates across all groups and
// latches the totals into readable result registers.
//
// Optional build macro: CONV3_SIGNED_EN (signed arithmetic, sign-extended
// results). Default build is unsigned with zero-extended results.
//
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_we, i_write_addr,  write strobe/address/data
//   i_data
//   i_re, i_read_addr    read strobe/address
//   o_data               combinational read data (0 when i_re=0)
//   o_busy               run in progress
//   o_done               sticky completion flag
//
// Bus semantics: a write takes effect on the rising edge where i_we is high;
// there is no back-pressure. o_data is valid in the same cycle i_re is high;
// a STATUS read clears done/err on the edge that ends that cycle, and a
// completion landing on that same edge keeps done set.
// -----------------------------------------------------------------------------
module conv3_seq_engine
    import conv3_seq_pkg::*;
#(
    parameter int PRECISION_WIDTH = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 14,
    parameter int CHANNELS        = 64,
    parameter int OUT_POINTS      = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_write_addr,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_read_addr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int LANES     = f_lanes(DATA_WIDTH, PRECISION_WIDTH);
    localparam int GROUPS    = f_groups(CHANNELS, LANES);
    localparam int RAM_DEPTH = f_ram_depth(OUT_POINTS, GROUPS);
    localparam int PART_W    = f_part_w(PRECISION_WIDTH);
    localparam int ACC_W     = f_acc_w(PRECISION_WIDTH, GROUPS);
    localparam int RAM_AW    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int GRP_W     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int WT_BASE   = OUT_POINTS * GROUPS * TAPS;

    localparam logic [ADDR_WIDTH-1:0] RAM_END     = ADDR_WIDTH'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR   = ADDR_WIDTH'(f_ctrl_addr(ADDR_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(f_status_addr(ADDR_WIDTH));
    localparam logic [GRP_W-1:0]      LAST_GRP    = GRP_W'(GROUPS - 1);

    function automatic logic [ACC_W-1:0] ext_part(input logic [PART_W-1:0] v);
`ifdef CONV3_SIGNED_EN
        return ACC_W'(signed'(v));
`else
        return ACC_W'(v);
`endif
    endfunction

    function automatic logic [DATA_WIDTH-1:0] ext_res(input logic [ACC_W-1:0] v);
`ifdef CONV3_SIGNED_EN
        return DATA_WIDTH'(signed'(v));
`else
        return DATA_WIDTH'(v);
`endif
    endfunction

    conv3_state_e     state_q, state_d;
    logic [GRP_W-1:0] grp_q, grp_d;
    logic [ACC_W-1:0] acc_q  [OUT_POINTS];
    logic [ACC_W-1:0] acc_d  [OUT_POINTS];
    logic [ACC_W-1:0] res_q  [OUT_POINTS];
    logic [ACC_W-1:0] res_d  [OUT_POINTS];
    logic [PART_W-1:0] part_q [OUT_POINTS];
    logic [PART_W-1:0] part_d [OUT_POINTS];
    logic [PART_W-1:0] mac_part [OUT_POINTS];
    logic             done_q, done_d;
    logic             err_q, err_d;
    conv3_dbg_t       dbg;

    // Operand storage; contents survive reset.
    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic busy, wr_ram, wr_start, rd_status;

    assign dbg       = '{state: state_q, err: err_q, done: done_q};
    assign busy      = (dbg.state != S_IDLE);
    assign wr_ram    = i_we && (i_write_addr < RAM_END);
    assign wr_start  = i_we && (i_write_addr == CTRL_ADDR) && i_data[0];
    assign rd_status = i_re && (i_read_addr == STATUS_ADDR);

    assign o_busy = busy;
    assign o_done = dbg.done;

    always_ff @(posedge i_clk) begin
        if (wr_ram && !busy) begin
            mem[RAM_AW'(i_write_addr)] <= i_data;
        end
    end

    // Per-point operand fetch for the group currently addressed by grp_q.
    for (genvar p = 0; p < OUT_POINTS; p++) begin : g_point
        logic [TAPS*DATA_WIDTH-1:0] dvec;
        logic [TAPS*DATA_WIDTH-1:0] wvec;

        always_comb begin
            dvec = '0;
            wvec = '0;
            for (int i = 0; i < TAPS; i++) begin
                dvec[i*DATA_WIDTH +: DATA_WIDTH] =
                    mem[RAM_AW'(p*GROUPS*TAPS + int'(grp_q)*TAPS + i)];
                wvec[i*DATA_WIDTH +: DATA_WIDTH] =
                    mem[RAM_AW'(WT_BASE + int'(grp_q)*TAPS + i)];
            end
        end

        conv3_group_mac #(
            .PRECISION_WIDTH(PRECISION_WIDTH),
            .DATA_WIDTH     (DATA_WIDTH)
        ) u_mac (
            .data_i   (dvec),
            .weight_i (wvec),
            .partial_o(mac_part[p])
        );
    end

    // Next-state logic. The partial of group g is registered on one edge and
    // folded into the accumulator on the next, so the last partial is added
    // while draining, directly into the result registers.
    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        acc_d   = acc_q;
        res_d   = res_q;
        part_d  = part_q;
        done_d  = done_q;
        err_d   = err_q;

        // Clears first so any set below on the same edge wins.
        if (rd_status) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end
        if (wr_ram && busy) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (wr_start) begin
                    state_d = S_RUN;
                    grp_d   = '0;
                    done_d  = 1'b0;
                    for (int p = 0; p < OUT_POINTS; p++) begin
                        acc_d[p] = '0;
                    end
                end
            end
            S_RUN: begin
                for (int p = 0; p < OUT_POINTS; p++) begin
                    part_d[p] = mac_part[p];
                    if (grp_q != '0) begin
                        acc_d[p] = acc_q[p] + ext_part(part_q[p]);
                    end
                end
                if (grp_q == LAST_GRP) begin
                    grp_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    grp_d = grp_q + 1'b1;
                end
            end
            S_DRAIN: begin
                for (int p = 0; p < OUT_POINTS; p++) begin
                    res_d[p] = acc_q[p] + ext_part(part_q[p]);
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            grp_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int p = 0; p < OUT_POINTS; p++) begin
                acc_q[p]  <= '0;
                res_q[p]  <= '0;
                part_q[p] <= '0;
            end
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            done_q  <= done_d;
            err_q   <= err_d;
            for (int p = 0; p < OUT_POINTS; p++) begin
                acc_q[p]  <= acc_d[p];
                res_q[p]  <= res_d[p];
                part_q[p] <= part_d[p];
            end
        end
    end

    always_comb begin
        o_data = '0;
        if (i_re) begin
            if (i_read_addr < RAM_END) begin
                o_data = mem[RAM_AW'(i_read_addr)];
            end else if (i_read_addr == STATUS_ADDR) begin
                o_data[STATUS_ERR_BIT]  = dbg.err;
                o_data[STATUS_BUSY_BIT] = busy;
                o_data[STATUS_DONE_BIT] = dbg.done;
            end else begin
                for (int p = 0; p < OUT_POINTS; p++) begin
                    if (i_read_addr == ADDR_WIDTH'(RAM_DEPTH + p)) begin
                        o_data = ext_res(res_q[p]);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_conv3_seq_engine.sv
`timescale 1ns/1ps
module tb_conv3_seq_engine;

    localparam int PW        = 4;
    localparam int DW        = 32;
    localparam int AW        = 14;
    localparam int CH        = 64;
    localparam int OP        = 2;
    localparam int LANES     = DW / PW;
    localparam int GROUPS    = CH / LANES;
    localparam int RAM_DEPTH = (OP + 1) * GROUPS * 9;
    localparam int WT_BASE   = OP * GROUPS * 9;
    localparam int CTRL      = (1 << AW) - 2;
    localparam int STATUS    = (1 << AW) - 1;
    localparam int DONE_LAT  = GROUPS + 1;

    // ---------------- clock / reset ----------------
    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_we = 1'b0;
    logic          i_re = 1'b0;
    logic [AW-1:0] i_write_addr = '0;
    logic [AW-1:0] i_read_addr = '0;
    logic [DW-1:0] i_data = '0;
    logic [DW-1:0] o_data;
    logic          o_busy;
    logic          o_done;

    always #5 i_clk = ~i_clk;

    conv3_seq_engine #(
        .PRECISION_WIDTH(PW),
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .CHANNELS       (CH),
        .OUT_POINTS     (OP)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_we        (i_we),
        .i_write_addr(i_write_addr),
        .i_data      (i_data),
        .i_re        (i_re),
        .i_read_addr (i_read_addr),
        .o_data      (o_data),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached, got running, required finished");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [DW-1:0] exp_q[$];
    string         name_q[$];
    int            tests = 0;
    int            fails = 0;

    // Reference model: memory image, result registers and flags.
    logic [DW-1:0] mem_m [RAM_DEPTH];
    logic [DW-1:0] res_m [OP];
    logic [DW-1:0] res_pend [OP];
    bit            busy_m = 0;
    bit            done_m = 0;
    bit            err_m = 0;

    function automatic void check(input string name, input logic [DW-1:0] act,
                                  input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    // Element of channel c, tap (r,k) in the block whose group 0 starts at base.
    function automatic int elem(input int base, input int c, input int r, input int k);
        int g  = c / LANES;
        int f  = (c % LANES) * 9 + r * 3 + k;
        int sh = DW - PW * ((f % LANES) + 1);
        logic [DW-1:0] w = mem_m[base + g * 9 + f / LANES];
        int v = int'((w >> sh) & ((1 << PW) - 1));
`ifdef CONV3_SIGNED_EN
        if (v >= (1 << (PW - 1))) v = v - (1 << PW);
`endif
        return v;
    endfunction

    // Full convolution result for point p: sum over channels and taps.
    function automatic logic [DW-1:0] model_result(input int p);
        longint acc = 0;
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < 3; r++)
                for (int k = 0; k < 3; k++)
                    acc += longint'(elem(p * GROUPS * 9, c, r, k)) * longint'(elem(WT_BASE, c, r, k));
        return DW'(acc);
    endfunction

    // ---------------- monitor ----------------
    always @(negedge i_clk) begin
        if (i_re) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_read: got 0x%08h at addr %0d, required a queued expectation",
                         o_data, i_read_addr);
            end else begin
                check(name_q.pop_front(), o_data, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_write(input int addr, input logic [DW-1:0] data);
        if (addr < RAM_DEPTH) begin
            if (busy_m) err_m = 1;
            else mem_m[addr] = data;
        end
        i_we = 1'b1;
        i_write_addr = AW'(addr);
        i_data = data;
        @(posedge i_clk);
        #1;
        i_we = 1'b0;
    endtask

    task automatic do_read(input int addr, input string name);
        logic [DW-1:0] e;
        e = '0;
        if (addr < RAM_DEPTH) e = mem_m[addr];
        else if (addr >= RAM_DEPTH && addr < RAM_DEPTH + OP) e = res_m[addr - RAM_DEPTH];
        else if (addr == STATUS) begin
            e = {29'd0, err_m, busy_m, done_m};
            done_m = 0;
            err_m = 0;
        end
        exp_q.push_back(e);
        name_q.push_back(name);
        i_re = 1'b1;
        i_read_addr = AW'(addr);
        @(posedge i_clk);
        #1;
        i_re = 1'b0;
    endtask

    // mode 0: fixed patterns, mode 1: random words
    task automatic fill(input logic [DW-1:0] dpat, input logic [DW-1:0] wpat, input bit rnd);
        for (int a = 0; a < RAM_DEPTH; a++) begin
            if (rnd) do_write(a, $urandom());
            else do_write(a, (a < WT_BASE) ? dpat : wpat);
        end
    endtask

    task automatic start_run();
        for (int p = 0; p < OP; p++) res_pend[p] = model_result(p);
        do_write(CTRL, 32'h1);
        busy_m = 1;
        done_m = 0;
        check("busy_after_start", {31'd0, o_busy}, 32'd1);
        check("done_cleared_at_start", {31'd0, o_done}, 32'd0);
    endtask

    task automatic wait_done(input int already);
        int cycles = already;
        while (!o_done && cycles < 60) begin
            @(posedge i_clk);
            cycles++;
            #1;
        end
        check("done_latency", cycles, DONE_LAT);
        check("busy_after_done", {31'd0, o_busy}, 32'd0);
        busy_m = 0;
        done_m = 1;
        for (int p = 0; p < OP; p++) res_m[p] = res_pend[p];
    endtask

    task automatic read_results(input string tag);
        for (int p = 0; p < OP; p++) do_read(RAM_DEPTH + p, $sformatf("%s_res%0d", tag, p));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int p = 0; p < OP; p++) begin
            res_m[p] = '0;
            res_pend[p] = '0;
        end
        repeat (3) @(posedge i_clk);
        #1;
        check("reset_busy", {31'd0, o_busy}, 32'd0);
        check("reset_done", {31'd0, o_done}, 32'd0);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        do_read(STATUS, "reset_status");
        read_results("reset");
        do_read(CTRL, "ctrl_reads_zero");
        do_read(RAM_DEPTH + OP + 5, "unmapped_read");

        // All ones: 576 per point.
        fill(32'h11111111, 32'h11111111, 0);
        do_read(0, "ram_first");
        do_read(RAM_DEPTH - 1, "ram_last");
        start_run();
        wait_done(0);
        read_results("ones");
        do_read(STATUS, "status_done");
        do_read(STATUS, "status_cleared");

        // All 0xF: unsigned maximum (129600), signed gives 576.
        fill(32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        start_run();
        wait_done(0);
        read_results("allf");

        // Data 0xF, weights 1: 8640 unsigned, -576 signed.
        fill(32'hFFFFFFFF, 32'h11111111, 0);
        start_run();
        wait_done(0);
        read_results("f_by_1");

        for (int t = 0; t < 3; t++) begin
            fill('0, '0, 1);
            start_run();
            wait_done(0);
            read_results($sformatf("rand%0d", t));
            do_read(STATUS, "rand_status");
        end

        // Writes to result and STATUS addresses are ignored.
        do_write(RAM_DEPTH, 32'hDEADBEEF);
        do_write(STATUS, 32'hFFFFFFFF);
        read_results("ro_after_write");
        do_read(STATUS, "status_after_ro_write");

        // Operand write and second start while busy.
        fill(32'h11111111, 32'h11111111, 0);
        start_run();
        do_write(0, 32'h0);
        do_write(CTRL, 32'h1);
        wait_done(2);
        read_results("midrun");
        do_read(0, "midrun_ram_kept");
        do_read(STATUS, "status_err_done");
        do_read(STATUS, "status_err_cleared");

        // Reset during cycle 4 of a run.
        start_run();
        repeat (3) @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        #2;
        check("reset_midrun_busy", {31'd0, o_busy}, 32'd0);
        check("reset_midrun_done", {31'd0, o_done}, 32'd0);
        busy_m = 0;
        done_m = 0;
        err_m = 0;
        for (int p = 0; p < OP; p++) res_m[p] = '0;
        #2;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        read_results("after_reset");
        do_read(STATUS, "status_after_reset");
        start_run();
        wait_done(0);
        read_results("restart");

        // CTRL write with bit0 clear does not start.
        do_write(CTRL, 32'h2);
        check("no_start_bit0_clear", {31'd0, o_busy}, 32'd0);

        // Read strobe low gives zero.
        i_read_addr = AW'(RAM_DEPTH);
        i_re = 1'b0;
        #1;
        check("re_low_zero", o_data, 32'd0);

        repeat (2) @(posedge i_clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
